// File: rtl/adc_scan_seq.sv
// adc_scan_seq: on SYNC, walks the enabled ADC mux channels in ascending order and emits one tagged sample per channel.
// Build option ADC_SCAN_AVG_EN: four back-to-back conversions per channel, averaged (truncated) into one sample.
module adc_scan_seq #(
    parameter int NCH         = 8,
    parameter int DW          = 12,
    parameter int SETTLE_CYC  = 24,
    parameter int TIMEOUT_CYC = 64,
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           sync,
    input  logic [NCH-1:0] ch_mask,
    output logic [CW-1:0]  mux_ch,
    output logic           conv_start,
    input  logic           conv_done,
    input  logic [DW-1:0]  conv_data,
    output logic           res_valid,
    output logic [CW-1:0]  res_ch,
    output logic [DW-1:0]  res_data,
    output logic           scan_done,
    output logic           busy,
    output logic           overrun,
    output logic           timeout,
    input  logic           err_clr
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
    localparam logic [TCW-1:0] WAIT_LAST   = TCW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_STORE
    } state_e;

    state_e          state_q;
    logic [NCH-1:0]  scan_mask_q;
    logic [CW-1:0]   mux_ch_q;
    logic [SCW-1:0]  settle_cnt_q;
    logic [TCW-1:0]  wait_cnt_q;
    logic            conv_start_q;
    logic            res_valid_q;
    logic [CW-1:0]   res_ch_q;
    logic [DW-1:0]   res_data_q;
    logic            scan_done_q;
    logic            busy_q;
    logic            overrun_q;
    logic            timeout_q;

`ifdef ADC_SCAN_AVG_EN
    localparam int AW = DW + 2;
    logic [AW-1:0]   acc_q;
    logic [1:0]      rep_q;
    logic [AW-1:0]   acc_sum;

    assign acc_sum = acc_q + AW'(conv_data);
`endif

    // Returns {found, index} of the lowest set bit of mask at or above position from.
    function automatic logic [CW:0] find_from(input logic [NCH-1:0] mask, input int from);
        logic [CW:0] hit;
        hit = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) hit = {1'b1, CW'(i)};
        end
        return hit;
    endfunction

    logic [CW:0] first_sel;
    logic [CW:0] next_sel;

    assign first_sel = find_from(ch_mask, 0);
    assign next_sel  = find_from(scan_mask_q, int'(mux_ch_q) + 1);

    // NOTE: every register here uses <= so all decisions in a cycle see the pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_IDLE;
            scan_mask_q  <= '0;
            mux_ch_q     <= '0;
            settle_cnt_q <= '0;
            wait_cnt_q   <= '0;
            conv_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_ch_q     <= '0;
            res_data_q   <= '0;
            scan_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_q        <= '0;
            rep_q        <= '0;
`endif
        end else begin
            conv_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            scan_done_q  <= 1'b0;

            // Clear first; any set event below in the same cycle overrides it.
            if (err_clr) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (sync && (state_q != ST_IDLE)) overrun_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (sync) begin
                        scan_mask_q <= ch_mask;
                        if (first_sel[CW]) begin
                            mux_ch_q     <= first_sel[CW-1:0];
                            settle_cnt_q <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= ST_SETTLE;
`ifdef ADC_SCAN_AVG_EN
                            acc_q        <= '0;
                            rep_q        <= '0;
`endif
                        end else begin
                            scan_done_q <= 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        conv_start_q <= 1'b1;
                        state_q      <= ST_START;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SCW'(1);
                    end
                end

                ST_START: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (conv_done) begin
`ifdef ADC_SCAN_AVG_EN
                        if (rep_q == 2'd3) begin
                            res_valid_q <= 1'b1;
                            res_ch_q    <= mux_ch_q;
                            res_data_q  <= acc_sum[AW-1:2];
                            scan_done_q <= !next_sel[CW];
                            state_q     <= ST_STORE;
                        end else begin
                            acc_q        <= acc_sum;
                            rep_q        <= rep_q + 2'd1;
                            conv_start_q <= 1'b1;
                            state_q      <= ST_START;
                        end
`else
                        res_valid_q <= 1'b1;
                        res_ch_q    <= mux_ch_q;
                        res_data_q  <= conv_data;
                        scan_done_q <= !next_sel[CW];
                        state_q     <= ST_STORE;
`endif
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Channel abandoned: pass through STORE with no result so advancing stays in one place.
                        timeout_q   <= 1'b1;
                        scan_done_q <= !next_sel[CW];
                        state_q     <= ST_STORE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TCW'(1);
                    end
                end

                ST_STORE: begin
                    if (next_sel[CW]) begin
                        mux_ch_q     <= next_sel[CW-1:0];
                        settle_cnt_q <= '0;
                        state_q      <= ST_SETTLE;
`ifdef ADC_SCAN_AVG_EN
                        acc_q        <= '0;
                        rep_q        <= '0;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mux_ch     = mux_ch_q;
    assign conv_start = conv_start_q;
    assign res_valid  = res_valid_q;
    assign res_ch     = res_ch_q;
    assign res_data   = res_data_q;
    assign scan_done  = scan_done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule
